// File: rtl/downsampler_4_pkg.sv
// Shared widths and the round/saturate helper for the 4x symbol-rate downsampler.
package downsampler_4_pkg;
  localparam int DS_DATA_W = 18;
  localparam int DS_ACC_W  = 21;
  localparam int PH_W      = 2;

  localparam logic signed [DS_ACC_W:0] SAT_MAX =
    {{(DS_ACC_W-DS_DATA_W+2){1'b0}}, {(DS_DATA_W-1){1'b1}}};
  localparam logic signed [DS_ACC_W:0] SAT_MIN =
    {{(DS_ACC_W-DS_DATA_W+2){1'b1}}, {(DS_DATA_W-1){1'b0}}};

  // Divide a symbol sum by 4 with round-half-up, then clamp to the output range.
  function automatic logic signed [DS_DATA_W-1:0] rnd_sat(input logic signed [DS_ACC_W-1:0] sum);
    logic signed [DS_ACC_W:0] r;
    r = (DS_ACC_W+1)'(sum) + (DS_ACC_W+1)'(2);
    r = r >>> 2;
    if (r > SAT_MAX)      return SAT_MAX[DS_DATA_W-1:0];
    else if (r < SAT_MIN) return SAT_MIN[DS_DATA_W-1:0];
    return r[DS_DATA_W-1:0];
  endfunction
endpackage

// File: rtl/downsampler_4_phase_ctrl.sv
// Capture-phase register: direct load plus one-step early/late nudges from timing recovery.
module phase_ctrl_4
  import downsampler_4_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            phase_load,
  input  logic [PH_W-1:0] phase_sel,
  input  logic            phase_adv,
  input  logic            phase_ret,
  input  logic            hit,
  output logic            dump,
  output logic [PH_W-1:0] offset
);
  logic pend, pend_adv, skip;

  // A late nudge moves offset onto the very next sample; skip that match so the
  // adjusted symbol spans 5 samples instead of producing a doubled capture.
  assign dump = hit && !skip;

  always_ff @(posedge clk) begin
    if (!reset) begin
      offset   <= '0;
      pend     <= 1'b0;
      pend_adv <= 1'b0;
      skip     <= 1'b0;
    end else if (phase_load) begin
      offset <= phase_sel;
      pend   <= 1'b0;
      skip   <= 1'b0;
    end else begin
      if (hit && skip) skip <= 1'b0;
      if (dump && pend) begin
        offset <= pend_adv ? offset - 1'b1 : offset + 1'b1;
        pend   <= 1'b0;
        skip   <= !pend_adv;
      end else if (!pend && (phase_adv ^ phase_ret)) begin
        pend     <= 1'b1;
        pend_adv <= phase_adv;
      end
    end
  end
endmodule

// File: rtl/downsampler_4.sv
// Receive-side 4:1 downsampler: pick one sample per symbol or integrate-and-dump.
module downsampler_4
  import downsampler_4_pkg::*;
#(
  parameter int DATA_W = DS_DATA_W,
  parameter int ACC_W  = DS_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sam_clk_en,
  input  logic                     sym_clk_en,
  input  logic                     mode,
  input  logic                     phase_load,
  input  logic [PH_W-1:0]          phase_sel,
  input  logic                     phase_adv,
  input  logic                     phase_ret,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     sym_valid,
  output logic [PH_W-1:0]          phase_cur
);
  logic [PH_W-1:0]         count_4, ph, offset;
  logic                    hit, dump;
  logic signed [ACC_W-1:0] acc, samp_ext, sum;

  assign ph       = sym_clk_en ? '0 : count_4;
  assign hit      = sam_clk_en && (ph == offset);
  assign samp_ext = {{(ACC_W-DATA_W){data_in[DATA_W-1]}}, data_in};
  assign sum      = acc + samp_ext;
  assign phase_cur = offset;

  phase_ctrl_4 u_phase (
    .clk        (clk),
    .reset      (reset),
    .phase_load (phase_load),
    .phase_sel  (phase_sel),
    .phase_adv  (phase_adv),
    .phase_ret  (phase_ret),
    .hit        (hit),
    .dump       (dump),
    .offset     (offset)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_4   <= '0;
      acc       <= '0;
      data_out  <= '0;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= dump;
      if (sam_clk_en)      count_4 <= ph + 1'b1;
      else if (sym_clk_en) count_4 <= '0;
      if (dump) data_out <= mode ? rnd_sat(sum) : data_in;
      // Loading a new phase starts a fresh integration window.
      if (!mode || phase_load) acc <= '0;
      else if (sam_clk_en)     acc <= dump ? '0 : sum;
    end
  end
endmodule

// File: tb/tb_downsampler_4.sv
// Scoreboard bench for downsampler_4: expected symbols queued at drive time, checked on sym_valid.
module tb_downsampler_4;
  logic               clk = 0, reset = 0, sam_clk_en = 0, sym_clk_en = 0, mode = 0;
  logic               phase_load = 0, phase_adv = 0, phase_ret = 0;
  logic [1:0]         phase_sel = 0, phase_cur;
  logic signed [17:0] data_in = 0, data_out;
  logic               sym_valid;
  int errs = 0, checks = 0, cyc = 0, n = 0;
  int exp_v[$], exp_c[$];

  downsampler_4 dut (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .mode(mode), .phase_load(phase_load), .phase_sel(phase_sel),
    .phase_adv(phase_adv), .phase_ret(phase_ret), .data_in(data_in),
    .data_out(data_out), .sym_valid(sym_valid), .phase_cur(phase_cur)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && sym_valid) begin
      if (exp_v.size() == 0) chk("extra_sym", 1, 0);
      else begin
        chk("sym_cyc", cyc, exp_c.pop_front());
        chk("sym_data", int'($signed(data_out)), exp_v.pop_front());
      end
    end
  end

  // One sample every 4 clocks; symbol strobe on every 4th sample.
  task automatic smp(input int d, input bit cap, input int e);
    @(negedge clk);
    sam_clk_en = 1; sym_clk_en = (n % 4 == 0); data_in = 18'(d);
    if (cap) begin exp_v.push_back(e); exp_c.push_back(cyc + 1); end
    n++;
    @(negedge clk);
    sam_clk_en = 0; sym_clk_en = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse(input bit adv, input bit ret, input bit ld, input logic [1:0] sel);
    @(negedge clk);
    phase_adv = adv; phase_ret = ret; phase_load = ld; phase_sel = sel;
    @(negedge clk);
    phase_adv = 0; phase_ret = 0; phase_load = 0;
    @(negedge clk);
  endtask

  task automatic iset(input int a, input int b, input int c, input int d, input int e);
    smp(a, 0, 0); smp(b, 0, 0); smp(c, 0, 0); smp(d, 1, e);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dout", int'($signed(data_out)), 0);
    chk("rst_vld", int'(sym_valid), 0);
    chk("rst_ph", int'(phase_cur), 0);
    reset = 1;

    // pick, offset 0
    for (int i = 0; i < 8; i++) smp(100 * (i % 4 + 1), i % 4 == 0, 100);
    // pick, offset 2
    pulse(0, 0, 1, 2);
    chk("load_ph2", int'(phase_cur), 2);
    for (int i = 0; i < 8; i++) smp(100 * (i % 4 + 1), i % 4 == 2, 300);

    // integrate-and-dump, offset 3, rounding cases
    pulse(0, 0, 1, 3);
    mode = 1;
    iset(1000, 1001, 1002, 1003, 1002);
    iset(-3, -3, -3, -3, -3);
    iset(1, 1, 0, 0, 1);
    iset(-1, -1, 0, 0, 0);
    iset(-3, 0, 0, 0, -1);

    // late nudge with wrap 3->0, then 5-sample symbol saturating high
    pulse(0, 1, 0, 0);
    iset(4, 4, 4, 4, 4);
    chk("ret_wrap_ph", int'(phase_cur), 0);
    for (int i = 0; i < 4; i++) smp(131071, 0, 0);
    smp(131071, 1, 131071);
    pulse(0, 1, 0, 0);
    iset(8, 8, 8, 8, 8);
    for (int i = 0; i < 4; i++) smp(-131072, 0, 0);
    smp(-131072, 1, -131072);
    chk("ret_ph1", int'(phase_cur), 1);

    // pick mode nudges: ret wrap, adv wrap, cancelled request
    mode = 0;
    pulse(0, 0, 1, 3);
    pulse(0, 1, 0, 0);
    smp(54, 0, 0); smp(55, 1, 55);
    chk("pk_ret_ph", int'(phase_cur), 0);
    pulse(1, 0, 0, 0);
    for (int k = 56; k <= 60; k++) smp(k, k == 60, k);
    chk("pk_adv_ph", int'(phase_cur), 3);
    pulse(1, 1, 0, 0);
    for (int k = 61; k <= 71; k++) smp(k, k == 63 || k == 67 || k == 71, k);
    chk("cancel_ph", int'(phase_cur), 3);

    // reset mid-accumulation
    mode = 1;
    smp(50000, 0, 0); smp(50000, 0, 0);
    @(negedge clk); reset = 0;
    @(negedge clk);
    chk("mid_rst_dout", int'($signed(data_out)), 0);
    chk("mid_rst_vld", int'(sym_valid), 0);
    chk("mid_rst_ph", int'(phase_cur), 0);
    reset = 1; n = 0;
    smp(40, 1, 10);
    pulse(0, 0, 1, 3);
    smp(20, 0, 0); smp(20, 0, 0); smp(20, 1, 15);

    repeat (4) @(negedge clk);
    chk("sb_drain", exp_v.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
